// File: rtl/phy_pkg.sv
// Shared types and constants for the channel frame reader: header format,
// FSM states and channel geometry.
package phy_pkg;

   localparam int         NUM_VCHN = 4;
   localparam int         ADDR_W   = 8;
   localparam int         DATA_W   = 32;
   localparam logic [7:0] HDR_TAG  = 8'hA0;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      DATA,
      DRAIN
   } state_t;

   // True when any channel numbered above vchn has a non-zero word count.
   function automatic logic later_nonzero(input logic [NUM_VCHN-1:0] nz,
                                          input logic [1:0]          vchn);
      logic found;
      found = 1'b0;
      for (int i = 0; i < NUM_VCHN; i++) begin
         if (i > int'(vchn)) found = found | nz[i];
      end
      return found;
   endfunction

   function automatic logic [DATA_W-1:0] header_word(input logic [1:0] vchn,
                                                     input logic [7:0] seq,
                                                     input logic [7:0] count);
      return {HDR_TAG + {6'd0, vchn}, 8'h00, seq, count};
   endfunction

endpackage

// File: rtl/phy_skid_fifo.sv
// Small synchronous FIFO with a registered output stage; an empty FIFO lets a
// pushed word fall straight into the output register.
module phy_skid_fifo #(
   parameter  int WIDTH = 34,
   parameter  int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             rdy,
   output logic             vld,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] mem_count_reg, mem_count_next;
   logic             out_vld_reg, out_vld_next;
   logic [WIDTH-1:0] out_data_reg;
   logic             pop, load_out, bypass, mem_wr, mem_rd;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      pop            = out_vld_reg && rdy;
      load_out       = !out_vld_reg || pop;
      mem_rd         = load_out && (mem_count_reg != '0);
      bypass         = load_out && (mem_count_reg == '0) && push;
      mem_wr         = push && !bypass;
      wr_ptr_next    = mem_wr ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
      rd_ptr_next    = mem_rd ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
      mem_count_next = mem_count_reg + CNT_W'(mem_wr) - CNT_W'(mem_rd);
      // A non-empty store always refills the output stage, so this covers both sources.
      out_vld_next   = load_out ? (mem_rd || push) : out_vld_reg;
   end

   always_ff @(posedge clk) begin
      if (mem_wr) mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         mem_count_reg <= '0;
         out_vld_reg   <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         mem_count_reg <= mem_count_next;
         out_vld_reg   <= out_vld_next;
         if (mem_rd)      out_data_reg <= mem[rd_ptr_reg];
         else if (bypass) out_data_reg <= din;
      end
   end

   assign vld   = out_vld_reg;
   assign dout  = out_data_reg;
   assign count = mem_count_reg + CNT_W'(out_vld_reg);

endmodule

// File: rtl/phy_frame_reader.sv
// Drains one frozen channel-buffer frame (4 headers, then payload of vchn 0..3)
// into a single valid/ready word stream, hiding RAM read latency behind a skid FIFO.
module phy_frame_reader
   import phy_pkg::*;
#(
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [15:0]       i_out_size,
   output logic [1:0]        o_rd_vchn,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [7:0]        i_data_count,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_vld,
   input  logic              i_rdy,
   output logic              o_sop,
   output logic              o_eop,
   output logic              o_busy,
   output logic              o_overrun,
   output logic              o_len_err
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int FIFO_W = DATA_W + 2;

   state_t              state_reg, state_next;
   logic [1:0]          vchn_reg, vchn_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [15:0]         out_size_reg;
   logic [15:0]         pop_count_reg;
   logic [7:0]          frame_seq_reg;
   logic [NUM_VCHN-1:0] nz_reg;
   logic                len_err_reg;
   logic                overrun_reg;
   logic [RD_LAT-1:0]   pipe_vld_reg;
   logic [RD_LAT-1:0]   pipe_eop_reg;

   logic [CNT_W-1:0]    fifo_count;
   logic                fifo_push, fifo_vld, fifo_pop, fifo_eop;
   logic [FIFO_W-1:0]   fifo_din, fifo_dout;
   logic [15:0]         inflight, occupancy;
   logic                credit, last_addr;
   logic                hdr_push, hdr_sop, hdr_eop;
   logic                rd_issue, rd_eop;
   logic                start_accept, frame_done;
   logic [DATA_W-1:0]   hdr_word;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + 16'(pipe_vld_reg[i]);
      occupancy = 16'(fifo_count) + inflight;
      credit    = occupancy < 16'(FIFO_DEPTH);
      last_addr = ({1'b0, addr_reg} + 9'd1) == {1'b0, i_data_count};
      fifo_pop  = fifo_vld && i_rdy;
      fifo_eop  = fifo_dout[DATA_W];
      hdr_word  = header_word(vchn_reg, frame_seq_reg, i_data_count);
      hdr_sop   = (vchn_reg == 2'd0);
      // Header 3 closes the frame only when no channel carries payload.
      hdr_eop   = (vchn_reg == 2'd3) && (nz_reg[2:0] == 3'b000) && (i_data_count == 8'd0);
   end

   always_comb begin
      state_next   = state_reg;
      vchn_next    = vchn_reg;
      addr_next    = addr_reg;
      hdr_push     = 1'b0;
      rd_issue     = 1'b0;
      rd_eop       = 1'b0;
      start_accept = 1'b0;
      frame_done   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_start) begin
               start_accept = 1'b1;
               state_next   = HDR;
               vchn_next    = 2'd0;
               addr_next    = '0;
            end
         end
         HDR: begin
            // Headers bypass the read pipe, so they must not overtake in-flight data.
            if (credit && (inflight == 16'd0)) begin
               hdr_push = 1'b1;
               if (vchn_reg == 2'd3) begin
                  state_next = DATA;
                  vchn_next  = 2'd0;
                  addr_next  = '0;
               end else begin
                  vchn_next = vchn_reg + 2'd1;
               end
            end
         end
         DATA: begin
            if (i_data_count == 8'd0 || credit) begin
               if (i_data_count != 8'd0) begin
                  rd_issue = 1'b1;
                  rd_eop   = last_addr && !later_nonzero(nz_reg, vchn_reg);
               end
               if (i_data_count == 8'd0 || last_addr) begin
                  addr_next = '0;
                  if (vchn_reg == 2'd3) state_next = DRAIN;
                  else                  vchn_next  = vchn_reg + 2'd1;
               end else begin
                  addr_next = addr_reg + 1'b1;
               end
            end
         end
         DRAIN: begin
            // Leave on the edge of the final transfer so busy drops right after it.
            if ((inflight == 16'd0) &&
                ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop))) begin
               state_next = IDLE;
               frame_done = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign fifo_push = hdr_push || pipe_vld_reg[RD_LAT-1];
   assign fifo_din  = hdr_push ? {hdr_sop, hdr_eop, hdr_word}
                               : {1'b0, pipe_eop_reg[RD_LAT-1], i_rd_data};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         vchn_reg      <= 2'd0;
         addr_reg      <= '0;
         out_size_reg  <= '0;
         pop_count_reg <= '0;
         frame_seq_reg <= '0;
         nz_reg        <= '0;
         len_err_reg   <= 1'b0;
         overrun_reg   <= 1'b0;
         pipe_vld_reg  <= '0;
         pipe_eop_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         vchn_reg    <= vchn_next;
         addr_reg    <= addr_next;
         overrun_reg <= i_start && (state_reg != IDLE);
         if (start_accept) begin
            out_size_reg  <= i_out_size;
            pop_count_reg <= '0;
            len_err_reg   <= 1'b0;
            nz_reg        <= '0;
         end else begin
            if (fifo_pop) pop_count_reg <= pop_count_reg + 16'd1;
            if (fifo_pop && fifo_eop && ((pop_count_reg + 16'd1) != out_size_reg))
               len_err_reg <= 1'b1;
         end
         if (hdr_push)   nz_reg[vchn_reg] <= (i_data_count != 8'd0);
         if (frame_done) frame_seq_reg    <= frame_seq_reg + 8'd1;
         pipe_vld_reg[0] <= rd_issue;
         pipe_eop_reg[0] <= rd_eop;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_reg[i] <= pipe_vld_reg[i-1];
            pipe_eop_reg[i] <= pipe_eop_reg[i-1];
         end
      end
   end

   phy_skid_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (fifo_din),
      .rdy   (i_rdy),
      .vld   (fifo_vld),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign o_rd_vchn = vchn_reg;
   assign o_rd_addr = addr_reg;
   assign o_vld     = fifo_vld;
   assign o_data    = fifo_dout[DATA_W-1:0];
   assign o_sop     = fifo_vld && fifo_dout[DATA_W+1];
   assign o_eop     = fifo_vld && fifo_dout[DATA_W];
   assign o_busy    = (state_reg != IDLE);
   assign o_overrun = overrun_reg;
   assign o_len_err = len_err_reg;

endmodule
